// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path definitions: bus widths, default boot PC and the buffer entry layout.
package inst_fetch_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [InstAddrBus-1:0] ResetPC = 32'h1c000000;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_buffer.sv
// Small {pc,inst} FIFO between the fetch FSM and decode; flush empties it in one edge.
module fetch_buffer
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_entry,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push, w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory request FSM feeding a 2-entry decode buffer.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC  = ResetPC,
  parameter int                     BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   inst_req_o,
  output logic [InstAddrBus-1:0] inst_addr_o,
  input  logic                   inst_ack_i,
  input  logic [InstBus-1:0]     inst_data_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]             r_state;
  logic [InstAddrBus-1:0] r_fetch_pc;
  logic [InstAddrBus-1:0] r_req_addr;

  logic         w_full, w_empty, w_pop, w_issue, w_ack, w_push;
  fetch_entry_t w_head, w_entry;

  assign inst_valid_o = !rst && !w_empty;
  assign pc_o         = inst_valid_o ? w_head.pc   : '0;
  assign inst_o       = inst_valid_o ? w_head.inst : '0;
  assign w_pop        = inst_valid_o && !stall_i;

  // New request only from IDLE, never in a redirect cycle, and only if the
  // buffer has room once this cycle's pop is counted.
  assign w_issue     = !rst && (r_state == S_IDLE) && !branch_flag_i && (!w_full || w_pop);
  assign inst_req_o  = w_issue || (!rst && (r_state != S_IDLE));
  assign inst_addr_o = rst ? RESET_PC : ((r_state == S_IDLE) ? r_fetch_pc : r_req_addr);

  assign w_ack   = inst_req_o && inst_ack_i;
  assign w_push  = w_ack && !branch_flag_i && (r_state != S_DROP);
  assign w_entry = '{pc: inst_addr_o, inst: inst_data_i};

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (branch_flag_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_entry (w_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      if (branch_flag_i)
        r_fetch_pc <= branch_target_i;
      else if (w_push)
        r_fetch_pc <= r_fetch_pc + 32'd4;

      if (w_issue)
        r_req_addr <= r_fetch_pc;

      case (r_state)
        S_IDLE:  if (w_issue && !inst_ack_i) r_state <= S_WAIT;
        S_WAIT:  if (w_ack) r_state <= S_IDLE;
                 else if (branch_flag_i) r_state <= S_DROP;
        // Redirects here only retarget fetch_pc; the stale response still has to drain.
        S_DROP:  if (w_ack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
